fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 28 ++
 rtl/fifo_arb_watchdog.sv | 47 ++++
 rtl/fifo_write_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared encodings for the FIFO write-port arbiter: FSM states, grant codes
// and the default byte width.
package fifo_arb_pkg;

    localparam int ARB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_0    = 2'b01;
    localparam logic [1:0] GRANT_1    = 2'b10;

    function automatic logic [1:0] state_to_grant(input arb_state_t s);
        logic [1:0] g;
        g = GRANT_NONE;
        case (s)
            OWN0:    g = GRANT_0;
            OWN1:    g = GRANT_1;
            default: g = GRANT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/fifo_arb_watchdog.sv
// Packet length and stall counters for the current owner; the hit outputs
// flag the cycle whose increment would reach the limit.
module fifo_arb_watchdog #(
    parameter int MAX_LEN  = 64,
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic len_clr,
    input  logic len_inc,
    input  logic wait_clr,
    input  logic wait_inc,
    output logic len_hit,
    output logic wait_hit
);

    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    logic [LEN_W-1:0]  len_reg;
    logic [WAIT_W-1:0] wait_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_reg <= '0;
        end else if (len_clr) begin
            len_reg <= '0;
        end else if (len_inc && (len_reg != LEN_W'(MAX_LEN))) begin
            len_reg <= len_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_reg <= '0;
        end else if (wait_clr) begin
            wait_reg <= '0;
        end else if (wait_inc && (wait_reg != WAIT_W'(WAIT_MAX))) begin
            wait_reg <= wait_reg + 1'b1;
        end
    end

    // Hit in the same cycle as the limiting increment so release happens on that edge.
    assign len_hit  = len_inc  && (len_reg  == LEN_W'(MAX_LEN - 1));
    assign wait_hit = wait_inc && (wait_reg == WAIT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-atomic round-robin arbiter sharing one FIFO write port between two
// byte producers, with stall watchdog and length-limit forced release.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W   = ARB_DATA_W,
    parameter int MAX_LEN  = 64,
    parameter int WAIT_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              last0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    input  logic              last1,
    output logic              ack1,
    input  logic              fifo_full,
    output logic              fifo_write,
    output logic [DATA_W-1:0] fifo_data,
    output logic [1:0]        grant,
    output logic              abort
);

    arb_state_t state_reg;
    logic       ptr_reg;
    logic       abort_reg;

    logic [1:0] req_vec;
    logic [1:0] last_vec;
    logic [1:0] own_vec;
    logic [1:0] ack_vec;

    logic owning, owner_req, owner_last, xfer;
    logic pkt_done, force_rel, release_now;
    logic len_hit, wait_hit;

    assign req_vec  = {req1, req0};
    assign last_vec = {last1, last0};
    assign own_vec  = {state_reg == OWN1, state_reg == OWN0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_vec[gi] = own_vec[gi] & req_vec[gi] & ~fifo_full;
        end
    endgenerate

    assign owning     = |own_vec;
    assign owner_req  = |(own_vec & req_vec);
    assign owner_last = |(own_vec & last_vec);
    assign xfer       = |ack_vec;

    // A length hit that coincides with last is an ordinary packet end.
    assign pkt_done    = xfer && owner_last;
    assign force_rel   = (len_hit && !owner_last) || wait_hit;
    assign release_now = pkt_done || force_rel;

    fifo_arb_watchdog #(
        .MAX_LEN  (MAX_LEN),
        .WAIT_MAX (WAIT_MAX)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .len_clr  (!owning || release_now),
        .len_inc  (xfer),
        .wait_clr (!owning || xfer || release_now),
        .wait_inc (owning && !owner_req),
        .len_hit  (len_hit),
        .wait_hit (wait_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            abort_reg <= 1'b0;
        end else begin
            abort_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (en && (|req_vec)) begin
                        if (req_vec[ptr_reg]) begin
                            state_reg <= ptr_reg ? OWN1 : OWN0;
                        end else begin
                            state_reg <= ptr_reg ? OWN0 : OWN1;
                        end
                    end
                end
                OWN0, OWN1: begin
                    if (release_now) begin
                        state_reg <= IDLE;
                        ptr_reg   <= (state_reg == OWN0);
                        abort_reg <= force_rel;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_data = '0;
        if (ack_vec[1]) begin
            fifo_data = data1;
        end else if (ack_vec[0]) begin
            fifo_data = data0;
        end
    end

    assign ack0       = ack_vec[0];
    assign ack1       = ack_vec[1];
    assign fifo_write = xfer;
    assign grant      = state_to_grant(state_reg);
    assign abort      = abort_reg;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a per-cycle vector table followed by
// hand-written backpressure, watchdog, length-limit and reset sequences.
module tb_fifo_write_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       req0, last0, ack0;
    logic [7:0] data0;
    logic       req1, last1, ack1;
    logic [7:0] data1;
    logic       fifo_full, fifo_write, abort;
    logic [7:0] fifo_data;
    logic [1:0] grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .DATA_W   (8),
        .MAX_LEN  (64),
        .WAIT_MAX (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .req0       (req0),
        .data0      (data0),
        .last0      (last0),
        .ack0       (ack0),
        .req1       (req1),
        .data1      (data1),
        .last1      (last1),
        .ack1       (ack1),
        .fifo_full  (fifo_full),
        .fifo_write (fifo_write),
        .fifo_data  (fifo_data),
        .grant      (grant),
        .abort      (abort)
    );

    typedef struct {
        logic       rs, en, r0;
        logic [7:0] d0;
        logic       l0, r1;
        logic [7:0] d1;
        logic       l1, full;
        logic       a0, a1, fw;
        logic [7:0] fd;
        logic [1:0] g;
        logic       ab;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rs, input logic e, input logic r0, input logic [7:0] d0,
                                input logic l0, input logic r1, input logic [7:0] d1, input logic l1,
                                input logic f, input logic a0, input logic a1, input logic fw,
                                input logic [7:0] fd, input logic [1:0] g, input logic ab);
        vec_t v;
        v.rs = rs; v.en = e; v.r0 = r0; v.d0 = d0; v.l0 = l0;
        v.r1 = r1; v.d1 = d1; v.l1 = l1; v.full = f;
        v.a0 = a0; v.a1 = a1; v.fw = fw; v.fd = fd; v.g = g; v.ab = ab;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic a0, input logic a1, input logic fw,
                           input logic [7:0] fd, input logic [1:0] g, input logic ab);
        chk({tag, ".ack0"}, 32'(ack0), 32'(a0));
        chk({tag, ".ack1"}, 32'(ack1), 32'(a1));
        chk({tag, ".fifo_write"}, 32'(fifo_write), 32'(fw));
        chk({tag, ".fifo_data"}, 32'(fifo_data), 32'(fd));
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".abort"}, 32'(abort), 32'(ab));
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle before sampling.
    task automatic step(input logic rs, input logic e, input logic r0, input logic [7:0] d0,
                        input logic l0, input logic r1, input logic [7:0] d1, input logic l1,
                        input logic f);
        @(negedge clk);
        reset = rs; en = e; req0 = r0; data0 = d0; last0 = l0;
        req1 = r1; data1 = d1; last1 = l1; fifo_full = f;
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int writes;
        int aborts;
        int idx;
        logic stop;

        reset = 1'b1; en = 1'b0; req0 = 1'b0; data0 = 8'h00; last0 = 1'b0;
        req1 = 1'b0; data1 = 8'h00; last1 = 1'b0; fifo_full = 1'b0;

        // rs en r0 d0 l0 r1 d1 l1 full | a0 a1 fw fd g ab
        // Single packet from requester 0, then pointer check via contention.
        tbl.push_back(mk(1,0,0,8'h00,0,0,8'h00,0,0, 0,0,0,8'h00,2'b00,0));
        tbl.push_back(mk(0,1,1,8'h02,0,0,8'h00,0,0, 0,0,0,8'h00,2'b00,0));
        tbl.push_back(mk(0,1,1,8'h02,0,0,8'h00,0,0, 1,0,1,8'h02,2'b01,0));
        tbl.push_back(mk(0,1,1,8'h03,0,0,8'h00,0,0, 1,0,1,8'h03,2'b01,0));
        tbl.push_back(mk(0,1,1,8'h04,0,0,8'h00,0,0, 1,0,1,8'h04,2'b01,0));
        tbl.push_back(mk(0,1,1,8'h05,1,0,8'h00,0,0, 1,0,1,8'h05,2'b01,0));
        tbl.push_back(mk(0,1,0,8'h00,0,0,8'h00,0,0, 0,0,0,8'h00,2'b00,0));
        tbl.push_back(mk(0,1,1,8'h06,1,1,8'hA0,1,0, 0,0,0,8'h00,2'b00,0));
        tbl.push_back(mk(0,1,1,8'h06,1,1,8'hA0,1,0, 0,1,1,8'hA0,2'b10,0));
        tbl.push_back(mk(0,1,1,8'h06,1,0,8'h00,0,0, 0,0,0,8'h00,2'b00,0));
        tbl.push_back(mk(0,1,1,8'h06,1,0,8'h00,0,0, 1,0,1,8'h06,2'b01,0));
        tbl.push_back(mk(0,1,0,8'h00,0,0,8'h00,0,0, 0,0,0,8'h00,2'b00,0));
        // Contention after reset: 0 first, then 1 while 0 waits, then 0 again.
        tbl.push_back(mk(1,0,0,8'h00,0,0,8'h00,0,0, 0,0,0,8'h00,2'b00,0));
        tbl.push_back(mk(0,1,1,8'h10,0,1,8'h20,0,0, 0,0,0,8'h00,2'b00,0));
        tbl.push_back(mk(0,1,1,8'h10,0,1,8'h20,0,0, 1,0,1,8'h10,2'b01,0));
        tbl.push_back(mk(0,1,1,8'h11,0,1,8'h20,0,0, 1,0,1,8'h11,2'b01,0));
        tbl.push_back(mk(0,1,1,8'h12,1,1,8'h20,0,0, 1,0,1,8'h12,2'b01,0));
        tbl.push_back(mk(0,1,1,8'h30,0,1,8'h20,0,0, 0,0,0,8'h00,2'b00,0));
        tbl.push_back(mk(0,1,1,8'h30,0,1,8'h20,0,0, 0,1,1,8'h20,2'b10,0));
        tbl.push_back(mk(0,1,1,8'h30,0,1,8'h21,0,0, 0,1,1,8'h21,2'b10,0));
        tbl.push_back(mk(0,1,1,8'h30,0,1,8'h22,1,0, 0,1,1,8'h22,2'b10,0));
        tbl.push_back(mk(0,1,1,8'h30,0,0,8'h00,0,0, 0,0,0,8'h00,2'b00,0));
        tbl.push_back(mk(0,1,1,8'h30,0,0,8'h00,0,0, 1,0,1,8'h30,2'b01,0));
        tbl.push_back(mk(0,1,1,8'h31,0,0,8'h00,0,0, 1,0,1,8'h31,2'b01,0));
        tbl.push_back(mk(0,1,1,8'h32,1,0,8'h00,0,0, 1,0,1,8'h32,2'b01,0));
        tbl.push_back(mk(0,1,0,8'h00,0,0,8'h00,0,0, 0,0,0,8'h00,2'b00,0));
        // en low blocks new grants but not a packet already in progress.
        tbl.push_back(mk(0,0,0,8'h00,0,1,8'h50,0,0, 0,0,0,8'h00,2'b00,0));
        tbl.push_back(mk(0,0,0,8'h00,0,1,8'h50,0,0, 0,0,0,8'h00,2'b00,0));
        tbl.push_back(mk(0,1,0,8'h00,0,1,8'h50,0,0, 0,0,0,8'h00,2'b00,0));
        tbl.push_back(mk(0,0,0,8'h00,0,1,8'h50,0,0, 0,1,1,8'h50,2'b10,0));
        tbl.push_back(mk(0,0,0,8'h00,0,1,8'h51,1,1, 0,0,0,8'h00,2'b10,0));
        tbl.push_back(mk(0,0,0,8'h00,0,1,8'h51,1,0, 0,1,1,8'h51,2'b10,0));
        tbl.push_back(mk(0,0,0,8'h00,0,0,8'h00,0,0, 0,0,0,8'h00,2'b00,0));

        foreach (tbl[i]) begin
            step(tbl[i].rs, tbl[i].en, tbl[i].r0, tbl[i].d0, tbl[i].l0,
                 tbl[i].r1, tbl[i].d1, tbl[i].l1, tbl[i].full);
            $display("vec %0d: grant=%b ack=%b%b write=%b data=%h abort=%b",
                     i, grant, ack1, ack0, fifo_write, fifo_data, abort);
            chk_out($sformatf("vec%0d", i), tbl[i].a0, tbl[i].a1, tbl[i].fw,
                    tbl[i].fd, tbl[i].g, tbl[i].ab);
        end

        // Backpressure: ten full cycles mid-packet from requester 1.
        step(1,0,0,8'h00,0,0,8'h00,0,0);
        step(0,1,0,8'h00,0,1,8'h60,0,0);
        chk_out("bp_idle", 0,0,0,8'h00,2'b00,0);
        for (int k = 0; k < 2; k++) begin
            step(0,1,0,8'h00,0,1,8'(8'h60 + k),0,0);
            chk_out("bp_pre", 0,1,1,8'(8'h60 + k),2'b10,0);
        end
        for (int k = 0; k < 10; k++) begin
            step(0,1,0,8'h00,0,1,8'h62,0,1);
            chk_out("bp_full", 0,0,0,8'h00,2'b10,0);
        end
        for (int k = 2; k < 6; k++) begin
            step(0,1,0,8'h00,0,1,8'(8'h60 + k),(k == 5),0);
            chk_out("bp_post", 0,1,1,8'(8'h60 + k),2'b10,0);
        end
        step(0,1,0,8'h00,0,0,8'h00,0,0);
        chk_out("bp_end", 0,0,0,8'h00,2'b00,0);
        $display("seq backpressure: done");

        // Watchdog: owner 0 stalls after two bytes while requester 1 waits.
        step(1,0,0,8'h00,0,0,8'h00,0,0);
        step(0,1,1,8'h70,0,1,8'h80,0,0);
        chk_out("wd_idle", 0,0,0,8'h00,2'b00,0);
        step(0,1,1,8'h70,0,1,8'h80,0,0);
        chk_out("wd_b0", 1,0,1,8'h70,2'b01,0);
        step(0,1,1,8'h71,0,1,8'h80,0,0);
        chk_out("wd_b1", 1,0,1,8'h71,2'b01,0);
        for (int s = 1; s <= 16; s++) begin
            step(0,1,0,8'h00,0,1,8'h80,0,0);
            chk_out($sformatf("wd_stall%0d", s), 0,0,0,8'h00,2'b01,0);
        end
        step(0,1,0,8'h00,0,1,8'h80,1,0);
        chk_out("wd_abort", 0,0,0,8'h00,2'b00,1);
        step(0,1,0,8'h00,0,1,8'h80,1,0);
        chk_out("wd_regrant", 0,1,1,8'h80,2'b10,0);
        step(0,1,0,8'h00,0,0,8'h00,0,0);
        chk_out("wd_end", 0,0,0,8'h00,2'b00,0);
        $display("seq watchdog: done");

        // Length limit: requester 1 offers 70 bytes with no last; gives up on abort.
        step(1,0,0,8'h00,0,0,8'h00,0,0);
        writes = 0; aborts = 0; idx = 0; stop = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step(0,1,0,8'h00,0,(!stop && idx < 70),8'(idx),0,0);
            if (fifo_write) begin
                chk("len_data", 32'(fifo_data), 32'(8'(idx)));
                writes++;
                idx++;
            end
            if (abort) begin
                aborts++;
                chk("len_writes_at_abort", 32'(writes), 32'd64);
                chk("len_grant_at_abort", 32'(grant), 32'd0);
                stop = 1'b1;
                req1 = 1'b0;
            end
        end
        chk("len_total_writes", 32'(writes), 32'd64);
        chk("len_abort_count", 32'(aborts), 32'd1);
        $display("seq length: writes=%0d aborts=%0d", writes, aborts);

        // Reset mid-packet while pointer is 1; afterwards contention must favour 0.
        step(1,0,0,8'h00,0,0,8'h00,0,0);
        step(0,1,1,8'hA1,1,0,8'h00,0,0);
        step(0,1,1,8'hA1,1,0,8'h00,0,0);
        chk_out("rs_pkt0", 1,0,1,8'hA1,2'b01,0);
        step(0,1,0,8'h00,0,1,8'hB0,0,0);
        chk_out("rs_idle", 0,0,0,8'h00,2'b00,0);
        for (int k = 0; k < 3; k++) begin
            step(0,1,0,8'h00,0,1,8'(8'hB0 + k),0,0);
            chk_out("rs_byte", 0,1,1,8'(8'hB0 + k),2'b10,0);
        end
        step(1,1,0,8'h00,0,1,8'hB3,0,0);
        chk_out("rs_assert", 0,0,0,8'h00,2'b00,0);
        step(1,1,0,8'h00,0,1,8'hB3,0,0);
        chk_out("rs_hold", 0,0,0,8'h00,2'b00,0);
        step(0,1,0,8'h00,0,0,8'h00,0,0);
        chk_out("rs_release", 0,0,0,8'h00,2'b00,0);
        step(0,1,1,8'hC0,1,1,8'hD0,1,0);
        chk_out("rs_cont_idle", 0,0,0,8'h00,2'b00,0);
        step(0,1,1,8'hC0,1,1,8'hD0,1,0);
        chk_out("rs_ptr0", 1,0,1,8'hC0,2'b01,0);
        step(0,1,0,8'h00,0,0,8'h00,0,0);
        $display("seq reset_mid_packet: done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
